// File: rtl/mojolock_pkg.sv
// mojolock_pkg: shared widths, issue FSM states and the result record for sample_accumulator.
package mojolock_pkg;
  localparam int DW = 16;
  localparam int SHIFT_W = 4;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  typedef struct packed {
    logic [DW-1:0]      num;
    logic [DW-1:0]      den;
    logic [SHIFT_W-1:0] shift;
  } result_t;
  localparam result_t RES_RST = '{num: '0, den: 16'd1, shift: '0};
endpackage

// File: rtl/sample_accumulator_if.sv
// sample_accumulator_if: sample stream in, divider operands/handshake out.
interface sample_accumulator_if;
  import mojolock_pkg::*;
  logic               smp_valid;
  logic [DW-1:0]      smp_num;
  logic [DW-1:0]      smp_den;
  logic [SHIFT_W-1:0] shift_cfg;
  logic               once;
  logic [DW-1:0]      in0;
  logic [DW-1:0]      in1;
  logic [SHIFT_W-1:0] shift;
  logic               done;
  logic               busy;
  logic               dz;
  logic               overrun;
  modport master (
    input  smp_valid, smp_num, smp_den, shift_cfg, done,
    output once, in0, in1, shift, busy, dz, overrun
  );
  modport slave (
    output smp_valid, smp_num, smp_den, shift_cfg, done,
    input  once, in0, in1, shift, busy, dz, overrun
  );
endinterface

// File: rtl/sample_accumulator_acc_mean.sv
// acc_mean: window accumulators and mean reduction; SAMPLE_ACC_ROUND_EN selects round-half-up instead of floor.
module acc_mean
  import mojolock_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smp_valid,
  input  logic [DW-1:0]      smp_num,
  input  logic [DW-1:0]      smp_den,
  input  logic [SHIFT_W-1:0] shift_cfg,
  output logic               win_done,
  output result_t            res,
  output logic               dz
);
  localparam int AW = DW + WIN_LOG2;
  localparam int CW = WIN_LOG2 > 0 ? WIN_LOG2 : 1;
`ifdef SAMPLE_ACC_ROUND_EN
  localparam int BIAS = (1 << WIN_LOG2) >> 1;
`else
  localparam int BIAS = 0;
`endif
  logic signed [AW-1:0] acc_num, sum_num, rnd_num;
  logic        [AW-1:0] acc_den, sum_den, rnd_den;
  logic        [CW-1:0] cnt;
  logic                 last;
  logic        [DW-1:0] mean_den;
  // The mean is the 16-bit slice above the window bits, i.e. the shifted sum truncated.
  always_comb begin
    last = WIN_LOG2 == 0 || cnt == CW'((1 << WIN_LOG2) - 1);
    win_done = smp_valid && last;
    sum_num = acc_num + AW'(signed'(smp_num));
    sum_den = acc_den + AW'(smp_den);
    rnd_num = sum_num + AW'(BIAS);
    rnd_den = sum_den + AW'(BIAS);
    mean_den = rnd_den[WIN_LOG2 +: DW];
    res.num = rnd_num[WIN_LOG2 +: DW];
    res.den = mean_den == '0 ? DW'(1) : mean_den;
    res.shift = shift_cfg;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_num <= '0;
      acc_den <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else begin
      dz <= win_done && mean_den == '0;
      if (smp_valid) begin
        acc_num <= last ? '0 : sum_num;
        acc_den <= last ? '0 : sum_den;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
endmodule

// File: rtl/sample_accumulator.sv
// sample_accumulator: window-averaging front end issuing mean pairs to the divider; SAMPLE_ACC_ROUND_EN enables rounding.
module sample_accumulator
  import mojolock_pkg::*;
#(
  parameter int WIN_LOG2 = 4,
  parameter int DW = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sample_accumulator_if.master bus
);
  if (DW != mojolock_pkg::DW || WIN_LOG2 < 0 || WIN_LOG2 > 8) begin : g_bad_cfg
    $error("sample_accumulator: DW must be 16 and WIN_LOG2 in 0..8");
  end
  state_t  state;
  result_t ops, pend, res;
  logic    pend_valid, win_done, once, busy, overrun, dz;
  acc_mean #(.WIN_LOG2(WIN_LOG2)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .smp_valid(bus.smp_valid),
    .smp_num  (bus.smp_num),
    .smp_den  (bus.smp_den),
    .shift_cfg(bus.shift_cfg),
    .win_done (win_done),
    .res      (res),
    .dz       (dz)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ops <= RES_RST;
      pend <= RES_RST;
      pend_valid <= 1'b0;
      once <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      once <= 1'b0;
      overrun <= 1'b0;
      // A window arriving while the divider is occupied goes to the single pending slot.
      if (win_done && state != IDLE && !(state == WAIT && bus.done)) begin
        if (pend_valid) overrun <= 1'b1;
        else begin
          pend <= res;
          pend_valid <= 1'b1;
        end
      end
      case (state)
        IDLE: if (win_done) begin
          ops <= res;
          once <= 1'b1;
          busy <= 1'b1;
          state <= START;
        end
        START: state <= WAIT;
        WAIT: if (bus.done) begin
          if (pend_valid) begin
            ops <= pend;
            once <= 1'b1;
            state <= START;
            if (win_done) pend <= res;
            else pend_valid <= 1'b0;
          end else if (win_done) begin
            ops <= res;
            once <= 1'b1;
            state <= START;
          end else begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.once = once;
  assign bus.in0 = ops.num;
  assign bus.in1 = ops.den;
  assign bus.shift = ops.shift;
  assign bus.busy = busy;
  assign bus.dz = dz;
  assign bus.overrun = overrun;
endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Window-averaging front end for the fixed-point divider. It accumulates 2^WIN_LOG2 valid numerator/denominator sample pairs and reduces each window to 16-bit means. It presents each result pair as the divider's operands with a one-cycle start pulse, then waits for the divider's done. One pending-result slot absorbs divider back-pressure; further overflow is counted as overrun.

## Interface
- WIN_LOG2, default 4: window length is 2^WIN_LOG2 samples; legal range 0..8.
- DW, default 16: sample and operand width; fixed at 16.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- smp_valid  in  1  sample strobe; the sample is accepted on every cycle where it is high.
- smp_num  in  16  numerator sample, two's complement.
- smp_den  in  16  denominator sample, unsigned.
- shift_cfg  in  4  shift code; sampled together with the window's last sample.
- once  out  1  divider start, a one-cycle pulse.
- in0  out  16  numerator mean, signed.
- in1  out  16  denominator mean, unsigned, never 0.
- shift  out  4  shift code belonging to in0/in1.
- done  in  1  divider completion pulse.
- busy  out  1  high from the operand load until done is received.
- dz  out  1  one-cycle pulse when a window's denominator mean was 0 and was replaced by 1.
- overrun  out  1  one-cycle pulse when a completed window is dropped.

## Operation
- Accumulators:
  - acc_num is signed, DW+WIN_LOG2 bits; acc_den is unsigned, DW+WIN_LOG2 bits.
  - cnt is a WIN_LOG2-bit counter of accepted samples.
- Window completion: smp_valid with cnt == 2^WIN_LOG2-1.
  - sum = acc + current sample.
  - mean_num = sum_num >>> WIN_LOG2 (arithmetic shift); mean_den = sum_den >> WIN_LOG2.
  - On the same edge, the accumulators and cnt clear to 0.
- If mean_den == 0, it is replaced by 16'd1 and dz pulses on the following cycle.
- Issue FSM has three states: IDLE, START, WAIT.
  - IDLE: a window completes -> load in0/in1/shift, go to START.
  - START: once = 1 for exactly one cycle -> WAIT.
  - WAIT: on done, if pend_valid is set, load operands from the pending slot, clear pend_valid, go to START; otherwise go to IDLE.
- Window completes while the FSM is not in IDLE:
  - Pending slot empty -> store the result in the pending slot.
  - Pending slot full -> discard the new result, keep the older one, pulse overrun.
- Window completion and done in the same cycle while in WAIT:
  - Pending slot full -> the pending result moves to the operands and the new result moves into pending; no overrun.
  - Pending slot empty -> the new result loads the operands directly; go to START.
- in0, in1 and shift stay stable from the load until the next load.
- done received outside WAIT is ignored.

## Timing
- Reset values: once 0, in0 0, in1 16'd1, shift 0, busy 0, dz 0, overrun 0.
- Reset also clears the FSM (to IDLE), accumulators, cnt and pend_valid.
- Latency from the edge accepting the last sample:
  - Operands valid after that edge.
  - once high in the next cycle.
- busy is registered: high from the operand load through the cycle in which done is sampled.
- Back-to-back issue: done at cycle t gives once at t+1 (via START) when the pending slot was full. This is legal because the divider is idle again once its done is asserted.
- WIN_LOG2 = 0: every valid sample completes a window; cnt is unused.
- Asserting rst_n low mid-WAIT aborts the operation immediately; the divider's eventual done is ignored.

## Configuration
- SAMPLE_ACC_ROUND_EN defined: both means round to nearest, half rounds toward +inf.
  - mean = (sum + 2^(WIN_LOG2-1)) >> WIN_LOG2; with WIN_LOG2 = 0 no bias is added.
  - The result cannot overflow: the maximum numerator mean stays 32767.
- SAMPLE_ACC_ROUND_EN undefined: plain arithmetic/logical shift, i.e. floor.

## Structure
- Shared package mojolock_pkg holds:
  - DW = 16 and SHIFT_W = 4.
  - The issue FSM enum: IDLE, START, WAIT.
  - A result struct {num, den, shift}, used for both the operand and pending registers.
- One sub-module, acc_mean: accumulators, cnt, rounding and zero-denominator substitution.
  - Outputs: a win_done strobe plus the result struct and dz.
  - The top level holds the issue FSM and the pending slot.

## Test plan
- WIN_LOG2=2; four samples num=100, den=8, shift_cfg=4 -> in0=100, in1=8, shift=4; once high one cycle after the fourth sample; busy until done.
- Samples num -3, -3, -2, -2 (sum -10) -> in0=-3 without SAMPLE_ACC_ROUND_EN, in0=-2 with it.
- Denominators 0, 0, 1, 2 (sum 3, mean 0) -> in1=1; dz pulses once.
- done withheld; three windows complete -> the second is stored in pending, the third is dropped with one overrun pulse; then done -> once the next cycle with the second window's values.
- Pending slot full and done coincident with a window completion -> pending issued, new window pending, no overrun; the following done issues the new window.
- rst_n low during WAIT with a partial accumulation -> all outputs at reset values; the first once after release comes only after a full new window.
